branch_resolve: RTL

Branch resolution unit for the IF→ID boundary of the RV32I pipeline, the update-side counterpart of the tournament branch predictor. It latches each fetched instruction together with its prediction metadata and resolves conditional branches (opcode 1100011) in ID using the register operands. It raises a same-cycle redirect to pc_reg on a misprediction and returns a registered one-cycle training pulse (is_branch / take_or_not / pre_true / sel / pc) to the predictor. It also keeps saturating branch and misprediction counters.

---
 rtl/branch_resolve_if.sv | 39 +++
 rtl/branch_resolve.sv | 125 ++++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Bus between fetch/ID datapath, pc_reg and the branch predictor around the
// branch resolution unit. slave is the resolver view, master the driver view.
interface branch_resolve_if;
    logic        stall_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_pre_take_i;
    logic        if_pre_sel_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        id_is_branch;
    logic        id_take_or_not;
    logic        id_pre_true;
    logic        id_sel;
    logic [31:0] id_pc;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport slave (
        input  stall_i, if_pc_i, if_inst_i, if_pre_take_i, if_pre_sel_i,
               rs1_data_i, rs2_data_i,
        output id_pc_o, id_inst_o, id_valid_o, redirect_o, redirect_addr_o,
               id_is_branch, id_take_or_not, id_pre_true, id_sel, id_pc,
               branch_cnt_o, mispred_cnt_o
    );

    modport master (
        output stall_i, if_pc_i, if_inst_i, if_pre_take_i, if_pre_sel_i,
               rs1_data_i, rs2_data_i,
        input  id_pc_o, id_inst_o, id_valid_o, redirect_o, redirect_addr_o,
               id_is_branch, id_take_or_not, id_pre_true, id_sel, id_pc,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_resolve.sv
// IF/ID register with conditional-branch resolution in ID: same-cycle redirect
// on mispredict, one-cycle predictor training pulse, saturating statistics.
module branch_resolve (
    input  logic          clk,
    input  logic          rst,
    branch_resolve_if.slave br
);
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        pre_take_r;
    logic        pre_sel_r;
    logic        valid_r;

    logic        train_valid_r;
    logic        train_take_r;
    logic        train_true_r;
    logic        train_sel_r;
    logic [31:0] train_pc_r;

    logic [31:0] branch_cnt_r;
    logic [31:0] mispred_cnt_r;

    logic        is_branch_s;
    logic        legal_s;
    logic        actual_s;
    logic        resolve_s;
    logic        mispredict_s;
    logic [31:0] imm_s;
    logic [31:0] target_s;
    logic [31:0] fall_s;
    logic [31:0] redirect_addr_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Decode, evaluate and check the branch held in ID against its prediction
    always_comb begin
        is_branch_s     = valid_r && (inst_r[6:0] == 7'b1100011);
        legal_s         = 1'b1;
        actual_s        = 1'b0;
        imm_s           = {{19{inst_r[31]}}, inst_r[31], inst_r[7],
                           inst_r[30:25], inst_r[11:8], 1'b0};
        target_s        = pc_r + imm_s;
        fall_s          = pc_r + 32'd4;
        case (inst_r[14:12])
            3'b000:  actual_s = (br.rs1_data_i == br.rs2_data_i);
            3'b001:  actual_s = (br.rs1_data_i != br.rs2_data_i);
            3'b100:  actual_s = ($signed(br.rs1_data_i) <  $signed(br.rs2_data_i));
            3'b101:  actual_s = ($signed(br.rs1_data_i) >= $signed(br.rs2_data_i));
            3'b110:  actual_s = (br.rs1_data_i <  br.rs2_data_i);
            3'b111:  actual_s = (br.rs1_data_i >= br.rs2_data_i);
            default: begin
                legal_s  = 1'b0;
                actual_s = 1'b0;
            end
        endcase
        resolve_s    = is_branch_s && legal_s && !br.stall_i;
        mispredict_s = resolve_s && (pre_take_r != actual_s);
        if (mispredict_s) begin
            redirect_addr_s = actual_s ? target_s : fall_s;
        end else begin
            redirect_addr_s = 32'd0;
        end
    end

    // ID register: stall holds, a redirect squashes the wrong-path fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= 32'd0;
            inst_r     <= 32'd0;
            pre_take_r <= 1'b0;
            pre_sel_r  <= 1'b0;
            valid_r    <= 1'b0;
        end else if (br.stall_i) begin
            pc_r       <= pc_r;
            inst_r     <= inst_r;
            pre_take_r <= pre_take_r;
            pre_sel_r  <= pre_sel_r;
            valid_r    <= valid_r;
        end else begin
            pc_r       <= br.if_pc_i;
            inst_r     <= br.if_inst_i;
            pre_take_r <= br.if_pre_take_i;
            pre_sel_r  <= br.if_pre_sel_i;
            valid_r    <= !mispredict_s;
        end
    end

    // Training pulse to the predictor and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            train_valid_r <= 1'b0;
            train_take_r  <= 1'b0;
            train_true_r  <= 1'b0;
            train_sel_r   <= 1'b0;
            train_pc_r    <= 32'd0;
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else if (resolve_s) begin
            train_valid_r <= 1'b1;
            train_take_r  <= actual_s;
            train_true_r  <= !mispredict_s;
            train_sel_r   <= pre_sel_r;
            train_pc_r    <= pc_r;
            branch_cnt_r  <= sat_inc(branch_cnt_r);
            mispred_cnt_r <= mispredict_s ? sat_inc(mispred_cnt_r) : mispred_cnt_r;
        end else begin
            train_valid_r <= 1'b0;
        end
    end

    assign br.id_pc_o         = pc_r;
    assign br.id_inst_o       = inst_r;
    assign br.id_valid_o      = valid_r;
    assign br.redirect_o      = mispredict_s;
    assign br.redirect_addr_o = redirect_addr_s;
    assign br.id_is_branch    = train_valid_r;
    assign br.id_take_or_not  = train_take_r;
    assign br.id_pre_true     = train_true_r;
    assign br.id_sel          = train_sel_r;
    assign br.id_pc           = train_pc_r;
    assign br.branch_cnt_o    = branch_cnt_r;
    assign br.mispred_cnt_o   = mispred_cnt_r;
endmodule
